// File: rtl/counter_bcd_chain.sv
// Cascaded modulo-RADIX digit counter (BCD by default) with load, clear,
// up/down counting, terminal-count detection and optional saturation.
module counter_bcd_chain #(
  parameter int NUM_DIGITS = 2,
  parameter int RADIX      = 10,
  parameter int SATURATE   = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    up_dn,
  input  logic [4*NUM_DIGITS-1:0] din,
  output logic [4*NUM_DIGITS-1:0] dout,
  output logic                    cout,
  output logic                    tc,
  output logic                    sat
);

  localparam int         W      = 4 * NUM_DIGITS;
  localparam logic [3:0] MAXD   = 4'(RADIX - 1);
  localparam bit         SAT_EN = (SATURATE != 0);

  logic [W-1:0] count_q;
  logic [W-1:0] count_next;
  logic [W-1:0] load_value;
  logic         cout_q;
  logic         sat_q;
  logic         all_max;
  logic         all_zero;
  logic         ripple;
  logic [3:0]   digit;
  logic [3:0]   eff;

  // Out-of-range digits are treated as RADIX-1 for every carry/borrow decision.
  always_comb begin
    all_max    = 1'b1;
    all_zero   = 1'b1;
    ripple     = 1'b1;
    count_next = count_q;
    load_value = '0;
    digit      = '0;
    eff        = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      eff   = (digit > MAXD) ? MAXD : digit;
      if (eff != MAXD) all_max = 1'b0;
      if (eff != 4'd0) all_zero = 1'b0;
      if (ripple) begin
        if (up_dn) count_next[4*i +: 4] = (eff == MAXD) ? 4'd0 : 4'(eff + 4'd1);
        else       count_next[4*i +: 4] = (eff == 4'd0) ? MAXD : 4'(eff - 4'd1);
      end
      ripple = ripple && (up_dn ? (eff == MAXD) : (eff == 4'd0));
      load_value[4*i +: 4] = (din[4*i +: 4] > MAXD) ? MAXD : din[4*i +: 4];
    end
    tc = up_dn ? all_max : all_zero;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      cout_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      cout_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (load) begin
      count_q <= load_value;
      cout_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (enable) begin
      if (SAT_EN && tc) begin
        cout_q <= 1'b0;
        sat_q  <= 1'b1;
      end else begin
        count_q <= count_next;
        cout_q  <= tc;
        sat_q   <= 1'b0;
      end
    end else begin
      cout_q <= 1'b0;
    end
  end

  assign dout = count_q;
  assign cout = cout_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_counter_bcd_chain.sv
// Scoreboard bench: stimulus queues expected responses, a negedge monitor
// pops and compares them against one of three differently parameterised DUTs.
module tb_counter_bcd_chain;

  typedef struct {
    int          sel;
    logic [11:0] dout;
    logic        cout;
    logic        sat;
    logic        tc;
    string       name;
  } exp_t;

  logic        clock;
  logic        reset_n;
  logic        clear;
  logic        load;
  logic        enable;
  logic        up_dn;
  logic [7:0]  din8;
  logic [11:0] din12;

  logic [7:0]  dout0, dout1;
  logic [11:0] dout2;
  logic        cout0, cout1, cout2;
  logic        tc0, tc1, tc2;
  logic        sat0, sat1, sat2;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  counter_bcd_chain dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .enable(enable), .up_dn(up_dn), .din(din8),
    .dout(dout0), .cout(cout0), .tc(tc0), .sat(sat0)
  );

  counter_bcd_chain #(.NUM_DIGITS(2), .RADIX(10), .SATURATE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .enable(enable), .up_dn(up_dn), .din(din8),
    .dout(dout1), .cout(cout1), .tc(tc1), .sat(sat1)
  );

  counter_bcd_chain #(.NUM_DIGITS(3), .RADIX(6), .SATURATE(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .enable(enable), .up_dn(up_dn), .din(din12),
    .dout(dout2), .cout(cout2), .tc(tc2), .sat(sat2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name,
                             input logic [11:0] gd, input logic gc, input logic gs, input logic gt,
                             input logic [11:0] wd, input logic wc, input logic ws, input logic wt);
    checks++;
    if ({gd, gc, gs, gt} !== {wd, wc, ws, wt}) begin
      errors++;
      $display("[TB] FAIL %s: got dout=%h cout=%b sat=%b tc=%b, want dout=%h cout=%b sat=%b tc=%b",
               name, gd, gc, gs, gt, wd, wc, ws, wt);
    end
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        0:       checkOutput(mon_e.name, {4'h0, dout0}, cout0, sat0, tc0,
                             mon_e.dout, mon_e.cout, mon_e.sat, mon_e.tc);
        1:       checkOutput(mon_e.name, {4'h0, dout1}, cout1, sat1, tc1,
                             mon_e.dout, mon_e.cout, mon_e.sat, mon_e.tc);
        default: checkOutput(mon_e.name, dout2, cout2, sat2, tc2,
                             mon_e.dout, mon_e.cout, mon_e.sat, mon_e.tc);
      endcase
    end
  end

  task automatic pushExpected(input int sel, input logic [11:0] wd, input logic wc,
                              input logic ws, input logic wt, input string name);
    exp_t e;
    e.sel = sel; e.dout = wd; e.cout = wc; e.sat = ws; e.tc = wt; e.name = name;
    sb.push_back(e);
  endtask

  // Inputs change just after the falling edge so the monitor sees stable tc.
  task automatic applyStimulus(input logic c, input logic l, input logic e, input logic u,
                               input logic [11:0] d, input bit chk, input int sel,
                               input logic [11:0] wd, input logic wc, input logic ws,
                               input logic wt, input string name);
    @(negedge clock);
    #1;
    clear = c; load = l; enable = e; up_dn = u;
    din8 = d[7:0]; din12 = d;
    @(posedge clock);
    if (chk) pushExpected(sel, wd, wc, ws, wt, name);
  endtask

  initial begin
    int v;
    logic [7:0] w8;
    reset_n = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up_dn = 1'b1;
    din8 = '0; din12 = '0;

    #12;
    checkOutput("reset_dut0", {4'h0, dout0}, cout0, sat0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_dut1", {4'h0, dout1}, cout1, sat1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;

    // Full decade sweep 00..99 and the wrap back to 00.
    for (int k = 1; k <= 100; k++) begin
      v  = k % 100;
      w8 = 8'((v / 10) * 16 + (v % 10));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 0,
                    {4'h0, w8}, (k == 100), 1'b0, (v == 99), $sformatf("up_step_%0d", k));
    end
    applyStimulus(0, 0, 0, 1, 12'h000, 1, 0, 12'h000, 0, 0, 0, "hold_cout_drop");

    applyStimulus(0, 1, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 1, "load00_down_tc");
    applyStimulus(0, 0, 1, 0, 12'h000, 1, 0, 12'h099, 1, 0, 0, "down_borrow_99");
    applyStimulus(0, 0, 1, 0, 12'h000, 1, 0, 12'h098, 0, 0, 0, "down_98");

    applyStimulus(0, 1, 0, 1, 12'h0AF, 1, 0, 12'h099, 0, 0, 1, "load_clamp_AF");
    applyStimulus(1, 1, 0, 1, 12'h055, 1, 0, 12'h000, 0, 0, 0, "clear_over_load");

    applyStimulus(0, 1, 0, 1, 12'h098, 1, 1, 12'h098, 0, 0, 0, "sat_load98");
    applyStimulus(0, 0, 1, 1, 12'h000, 1, 1, 12'h099, 0, 0, 1, "sat_edge1");
    applyStimulus(0, 0, 1, 1, 12'h000, 1, 1, 12'h099, 0, 1, 1, "sat_edge2");
    applyStimulus(0, 0, 1, 1, 12'h000, 1, 1, 12'h099, 0, 1, 1, "sat_edge3");
    applyStimulus(0, 0, 0, 1, 12'h000, 1, 1, 12'h099, 0, 1, 1, "sat_hold_idle");
    applyStimulus(0, 0, 1, 0, 12'h000, 1, 1, 12'h098, 0, 0, 0, "sat_down_release");

    applyStimulus(0, 1, 0, 1, 12'h155, 1, 2, 12'h155, 0, 0, 0, "r6_load155");
    applyStimulus(0, 0, 1, 1, 12'h000, 1, 2, 12'h200, 0, 0, 0, "r6_ripple_200");
    applyStimulus(0, 1, 0, 1, 12'h555, 1, 2, 12'h555, 0, 0, 1, "r6_load555");
    applyStimulus(0, 0, 1, 1, 12'h000, 1, 2, 12'h000, 1, 0, 0, "r6_wrap_000");
    applyStimulus(0, 0, 1, 0, 12'h000, 1, 2, 12'h555, 1, 0, 0, "r6_borrow_555");
    applyStimulus(0, 1, 0, 1, 12'h9F7, 1, 2, 12'h555, 0, 0, 1, "r6_load_clamp");

    // Count to 45, then reset asynchronously between edges.
    applyStimulus(1, 0, 0, 1, 12'h000, 1, 0, 12'h000, 0, 0, 0, "clear_before_45");
    for (int k = 1; k <= 45; k++)
      applyStimulus(0, 0, 1, 1, 12'h000, (k == 45), 0, 12'h045, 0, 0, 0, "count_to_45");
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1 checkOutput("async_reset_45", {4'h0, dout0}, cout0, sat0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    @(posedge clock);
    pushExpected(0, 12'h001, 0, 0, 0, "first_edge_after_reset");

    // Reset during a cout pulse must kill the pulse.
    applyStimulus(0, 1, 0, 1, 12'h099, 1, 0, 12'h099, 0, 0, 1, "load99");
    applyStimulus(0, 0, 1, 1, 12'h000, 0, 0, 12'h000, 1, 0, 0, "wrap_unchecked");
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_mid_cout", {4'h0, dout0}, cout0, sat0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    #1 enable = 1'b0; reset_n = 1'b1;
    @(posedge clock);
    pushExpected(0, 12'h000, 0, 0, 0, "no_cout_after_reset");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
